// File: rtl/sifh_hist_ram_pkg.sv
// Shared constants for the SiFH histogram memory: default geometry and clear-FSM encoding.
package sifh_hist_ram_pkg;

  localparam int unsigned Nb      = 10;
  localparam int unsigned peakMax = 16;

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_READY = 1'b1;

endpackage

// File: rtl/sifh_dpram.sv
// Plain simple-dual-port array: one synchronous write port, one registered read port.
module sifh_dpram #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_q
);

  localparam int unsigned DEPTH = 2**AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read returns pre-write contents; same-address forwarding lives in the wrapper.
  always_ff @(posedge clk) begin
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_q = r_q;

endmodule

// File: rtl/sifh_hist_ram.sv
// Histogram bin memory with write-first collision forwarding and a post-reset/on-request clear sweep.
module sifh_hist_ram
  import sifh_hist_ram_pkg::*;
#(
  parameter int unsigned NB       = Nb,
  parameter int unsigned PEAK_MAX = peakMax
) (
  input  logic                clk,
  input  logic                res,
  input  logic [NB-1:0]       waddr,
  input  logic                wEnable,
  input  logic                writeFlag,
  input  logic [PEAK_MAX-1:0] newCounts,
  input  logic [NB-1:0]       raddr,
  input  logic                readFlag,
  input  logic                rEnable,
  output logic [PEAK_MAX-1:0] counts,
  input  logic                clrReq,
  output logic                clrBusy
);

  localparam int unsigned DEPTH = 2**NB;

  logic                r_state, w_state_nxt;
  logic [NB-1:0]       r_clr_ptr, w_clr_ptr_nxt;
  logic                r_clr_busy, w_clr_busy_nxt;
  logic                r_use_fwd;
  logic [PEAK_MAX-1:0] r_fwd_data;

  logic                w_in_clear;
  logic                w_wr_port;
  logic                w_rd_port;
  logic                w_collide;
  logic                w_mem_we;
  logic                w_mem_re;
  logic [NB-1:0]       w_mem_waddr;
  logic [PEAK_MAX-1:0] w_mem_wdata;
  logic [PEAK_MAX-1:0] w_mem_q;

  always_ff @(posedge clk) begin
    if (res) begin
      r_state    <= ST_CLEAR;
      r_clr_ptr  <= '0;
      r_clr_busy <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_ptr  <= w_clr_ptr_nxt;
      r_clr_busy <= w_clr_busy_nxt;
    end
  end

  // Sweep one bin per cycle; clrBusy falls on the edge that writes the last bin.
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_ptr_nxt  = r_clr_ptr;
    w_clr_busy_nxt = r_clr_busy;
    case (r_state)
      ST_CLEAR: begin
        w_clr_ptr_nxt = r_clr_ptr + NB'(1);
        if (r_clr_ptr == NB'(DEPTH - 1)) begin
          w_state_nxt    = ST_READY;
          w_clr_busy_nxt = 1'b0;
          w_clr_ptr_nxt  = '0;
        end
      end
      ST_READY: begin
        if (clrReq) begin
          w_state_nxt    = ST_CLEAR;
          w_clr_ptr_nxt  = '0;
          w_clr_busy_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt    = ST_CLEAR;
        w_clr_ptr_nxt  = '0;
        w_clr_busy_nxt = 1'b1;
      end
    endcase
  end

  assign w_in_clear  = (r_state == ST_CLEAR);
  assign w_wr_port   = writeFlag & wEnable;
  assign w_rd_port   = readFlag & ~rEnable;
  assign w_collide   = w_wr_port & (waddr == raddr);

  assign w_mem_we    = w_in_clear | w_wr_port;
  assign w_mem_waddr = w_in_clear ? r_clr_ptr : waddr;
  assign w_mem_wdata = w_in_clear ? '0 : newCounts;
  assign w_mem_re    = w_rd_port & ~w_in_clear;

  sifh_dpram #(
    .AW (NB),
    .DW (PEAK_MAX)
  ) u_dpram (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (w_mem_wdata),
    .i_re    (w_mem_re),
    .i_raddr (raddr),
    .o_q     (w_mem_q)
  );

  // Forward register carries collision data, and zeros for reads during the sweep.
  always_ff @(posedge clk) begin
    if (res) begin
      r_use_fwd  <= 1'b1;
      r_fwd_data <= '0;
    end else if (w_rd_port) begin
      if (w_in_clear) begin
        r_use_fwd  <= 1'b1;
        r_fwd_data <= '0;
      end else if (w_collide) begin
        r_use_fwd  <= 1'b1;
        r_fwd_data <= newCounts;
      end else begin
        r_use_fwd  <= 1'b0;
      end
    end
  end

  assign counts  = r_use_fwd ? r_fwd_data : w_mem_q;
  assign clrBusy = r_clr_busy;

endmodule

// File: tb/tb_sifh_hist_ram.sv
// Directed self-checking bench for sifh_hist_ram with NB=4, PEAK_MAX=8.
module tb_sifh_hist_ram;

  logic       clk = 1'b0;
  logic       res;
  logic [3:0] waddr;
  logic       wEnable;
  logic       writeFlag;
  logic [7:0] newCounts;
  logic [3:0] raddr;
  logic       readFlag;
  logic       rEnable;
  logic [7:0] counts;
  logic       clrReq;
  logic       clrBusy;

  int total = 0;
  int bad   = 0;

  sifh_hist_ram #(.NB(4), .PEAK_MAX(8)) dut (
    .clk       (clk),
    .res       (res),
    .waddr     (waddr),
    .wEnable   (wEnable),
    .writeFlag (writeFlag),
    .newCounts (newCounts),
    .raddr     (raddr),
    .readFlag  (readFlag),
    .rEnable   (rEnable),
    .counts    (counts),
    .clrReq    (clrReq),
    .clrBusy   (clrBusy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wEnable   = 1'b0;
    writeFlag = 1'b0;
    readFlag  = 1'b0;
    rEnable   = 1'b1;
    clrReq    = 1'b0;
  endtask

  task automatic set_write(input logic [3:0] a, input logic [7:0] d);
    waddr = a; newCounts = d; wEnable = 1'b1; writeFlag = 1'b1;
  endtask

  task automatic set_read(input logic [3:0] a);
    raddr = a; readFlag = 1'b1; rEnable = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    set_write(a, d); tick(); idle();
  endtask

  task automatic do_read(input logic [3:0] a);
    set_read(a); tick(); idle();
  endtask

  task automatic test_reset();
    int cnt;
    res = 1'b1;
    tick(); tick();
    res = 1'b0;
    total++;
    if (clrBusy !== 1'b1 || counts !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: clrBusy=%b counts=%h, want 1 00", clrBusy, counts);
    end
    cnt = 0;
    while (clrBusy === 1'b1 && cnt < 40) begin tick(); cnt++; end
    total++;
    if (cnt !== 16) begin
      bad++;
      $display("FAIL reset_sweep_len: %0d cycles, want 16", cnt);
    end
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i));
      total++;
      if (counts !== 8'h00) begin
        bad++;
        $display("FAIL reset_bin%0d: got %h, want 00", i, counts);
      end
    end
  endtask

  task automatic test_write_read();
    do_write(4'd3, 8'h5A);
    do_read(4'd3);
    total++;
    if (counts !== 8'h5A) begin
      bad++;
      $display("FAIL wr_rd_bin3: got %h, want 5a", counts);
    end
    do_read(4'd4);
    total++;
    if (counts !== 8'h00) begin
      bad++;
      $display("FAIL wr_rd_bin4: got %h, want 00", counts);
    end
  endtask

  task automatic test_collision();
    do_write(4'd7, 8'd9);
    set_write(4'd7, 8'd10); set_read(4'd7); tick(); idle();
    total++;
    if (counts !== 8'd10) begin
      bad++;
      $display("FAIL collide_same: got %0d, want 10", counts);
    end
    do_write(4'd7, 8'd9);
    set_write(4'd6, 8'd10); set_read(4'd7); tick(); idle();
    total++;
    if (counts !== 8'd9) begin
      bad++;
      $display("FAIL collide_diff: got %0d, want 9", counts);
    end
    do_read(4'd6);
    total++;
    if (counts !== 8'd10) begin
      bad++;
      $display("FAIL collide_bin6: got %0d, want 10", counts);
    end
  endtask

  task automatic test_gating();
    do_read(4'd3);
    total++;
    if (counts !== 8'h5A) begin
      bad++;
      $display("FAIL gate_pre: got %h, want 5a", counts);
    end
    raddr = 4'd4; readFlag = 1'b1; rEnable = 1'b1; tick(); idle();
    total++;
    if (counts !== 8'h5A) begin
      bad++;
      $display("FAIL gate_renable: got %h, want 5a", counts);
    end
    raddr = 4'd4; readFlag = 1'b0; rEnable = 1'b0; tick(); idle();
    total++;
    if (counts !== 8'h5A) begin
      bad++;
      $display("FAIL gate_readflag: got %h, want 5a", counts);
    end
    waddr = 4'd4; newCounts = 8'h33; wEnable = 1'b1; writeFlag = 1'b0; tick(); idle();
    waddr = 4'd5; newCounts = 8'h44; wEnable = 1'b0; writeFlag = 1'b1; tick(); idle();
    do_read(4'd4);
    total++;
    if (counts !== 8'h00) begin
      bad++;
      $display("FAIL gate_writeflag: got %h, want 00", counts);
    end
    do_read(4'd5);
    total++;
    if (counts !== 8'h00) begin
      bad++;
      $display("FAIL gate_wenable: got %h, want 00", counts);
    end
  endtask

  task automatic test_clear_req();
    int cnt;
    for (int i = 0; i < 16; i++) do_write(4'(i), 8'hFF);
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i));
      total++;
      if (counts !== 8'hFF) begin
        bad++;
        $display("FAIL fill_bin%0d: got %h, want ff", i, counts);
      end
    end
    clrReq = 1'b1; tick(); idle();
    total++;
    if (clrBusy !== 1'b1) begin
      bad++;
      $display("FAIL clr_rise: clrBusy=%b, want 1", clrBusy);
    end
    cnt = 0;
    while (clrBusy === 1'b1 && cnt < 40) begin
      if (cnt == 4) begin clrReq = 1'b1; set_read(4'd5); end
      if (cnt == 10) set_write(4'd2, 8'hAA);
      tick(); idle();
      cnt++;
      if (cnt == 5) begin
        total++;
        if (counts !== 8'h00) begin
          bad++;
          $display("FAIL clr_read_zero: got %h, want 00", counts);
        end
      end
    end
    total++;
    if (cnt !== 16) begin
      bad++;
      $display("FAIL clr_sweep_len: %0d cycles, want 16", cnt);
    end
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i));
      total++;
      if (counts !== 8'h00) begin
        bad++;
        $display("FAIL clr_bin%0d: got %h, want 00", i, counts);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    for (int i = 0; i < 16; i++) do_write(4'(i), 8'(8'h11 * (i + 1)));
    clrReq = 1'b1; tick(); idle();
    for (int i = 0; i < 8; i++) tick();
    res = 1'b1; tick(); res = 1'b0;
    total++;
    if (clrBusy !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy: clrBusy=%b, want 1", clrBusy);
    end
    cnt = 0;
    while (clrBusy === 1'b1 && cnt < 40) begin tick(); cnt++; end
    total++;
    if (cnt !== 16) begin
      bad++;
      $display("FAIL mid_sweep_len: %0d cycles, want 16", cnt);
    end
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i));
      total++;
      if (counts !== 8'h00) begin
        bad++;
        $display("FAIL mid_bin%0d: got %h, want 00", i, counts);
      end
    end
  endtask

  initial begin
    res = 1'b0; waddr = '0; raddr = '0; newCounts = '0;
    idle();
    test_reset();
    test_write_read();
    test_collision();
    test_gating();
    test_clear_req();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
